// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: NOP encoding, reset vector default and FSM states.
// ST_MISALIGN exists only when FETCH_MISALIGN_CHECK_EN is defined.
package instr_fetch_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_HOLD     = 3'd2,
        ST_FLUSH    = 3'd3
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        ST_MISALIGN = 3'd4
`endif
    } fetch_state_e;

    function automatic logic [31:0] align_target(input logic [31:0] target);
        return target & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_hold.sv
// Skid register that keeps the presented instruction/pc stable while decode stalls.
module fetch_hold
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] ins_in,
    input  logic [31:0] pc_in,
    output logic        hold_valid,
    output logic [31:0] hold_ins,
    output logic [31:0] hold_pc
);

    logic        valid_q, valid_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc_q, pc_d;

    // Clear wins so a redirect always discards a captured instruction.
    always_comb begin
        valid_d = valid_q;
        ins_d   = ins_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
            ins_d   = NOP_INSTR;
            pc_d    = 32'h0;
        end else if (load) begin
            valid_d = 1'b1;
            ins_d   = ins_in;
            pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ins_q   <= NOP_INSTR;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            ins_q   <= ins_d;
            pc_q    <= pc_d;
        end
    end

    assign hold_valid = valid_q;
    assign hold_ins   = ins_q;
    assign hold_pc    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues imem reads, presents ins/pc to decode, handles stall and redirect.
// Optional feature macro FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets in ST_MISALIGN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned IMEM_AW      = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mb_if__jump_target,
    input  logic               mb_if__branch_taken,
    input  logic               mb_if__trap_taken,
    input  logic               id_if__stall,
    input  logic [31:0]        imem_rdata,
    output logic               imem_read,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        if_id__pc,
    output logic [31:0]        if_id__ins,
    output logic               if_id__valid,
    output logic               if_id__ins_misalign,
    output logic               pipe_flush,
    output logic [2:0]         dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         valid_q, valid_d;
    logic         flush_q, flush_d;
    logic         redirect;
    logic         issue;
    logic         hold_load;
    logic         hold_clear;
    logic [31:0]  target;
    logic         hold_valid;
    logic [31:0]  hold_ins;
    logic [31:0]  hold_pc;

    assign redirect = mb_if__branch_taken | mb_if__trap_taken;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign target = mb_if__jump_target;
`else
    assign target = align_target(mb_if__jump_target);
`endif

    // Redirect takes precedence over stall in every state.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        issue      = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        if (redirect) begin
            hold_clear = 1'b1;
            fetch_pc_d = target;
            state_d    = ST_FLUSH;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (target[1:0] != 2'b00) begin
                state_d  = ST_MISALIGN;
                req_pc_d = target;
            end
`endif
        end else begin
            case (state_q)
                ST_BOOT, ST_FLUSH: begin
                    issue   = 1'b1;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (id_if__stall) begin
                        hold_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        issue = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!id_if__stall) begin
                        issue      = 1'b1;
                        hold_clear = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        if (issue) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        valid_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
        flush_d = (state_d == ST_FLUSH);
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d = (state_d == ST_MISALIGN);
        if (misalign_d) begin
            valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_VECTOR;
            req_pc_q   <= 32'h0;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
    assign if_id__ins_misalign = misalign_q;
`else
    assign if_id__ins_misalign = 1'b0;
`endif

    fetch_hold u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .clear      (hold_clear),
        .ins_in     (imem_rdata),
        .pc_in      (req_pc_q),
        .hold_valid (hold_valid),
        .hold_ins   (hold_ins),
        .hold_pc    (hold_pc)
    );

    // The read strobe is combinational, so it is gated while reset holds the FSM in BOOT.
    assign imem_read = issue & ~rst;
    assign imem_addr = fetch_pc_q[IMEM_AW+1:2];

    always_comb begin
        case (state_q)
            ST_RUN:  if_id__ins = imem_rdata;
            ST_HOLD: if_id__ins = hold_ins;
            default: if_id__ins = NOP_INSTR;
        endcase
    end

    assign if_id__pc    = (state_q == ST_HOLD) ? hold_pc : req_pc_q;
    assign if_id__valid = (state_q == ST_HOLD) ? hold_valid : valid_q;
    assign pipe_flush   = flush_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a decode-facing reference model checked every cycle.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] jump_target = 32'h0;
    logic        branch_taken = 1'b0;
    logic        trap_taken = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_read;
    logic [10:0] imem_addr;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        if_valid;
    logic        if_misalign;
    logic        pipe_flush;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    instr_fetch #(.RESET_VECTOR(32'h0), .IMEM_AW(11)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mb_if__jump_target  (jump_target),
        .mb_if__branch_taken (branch_taken),
        .mb_if__trap_taken   (trap_taken),
        .id_if__stall        (stall),
        .imem_rdata          (imem_rdata),
        .imem_read           (imem_read),
        .imem_addr           (imem_addr),
        .if_id__pc           (if_pc),
        .if_id__ins          (if_ins),
        .if_id__valid        (if_valid),
        .if_id__ins_misalign (if_misalign),
        .pipe_flush          (pipe_flush),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory contents: every word is a distinct function of its word address.
    function automatic logic [31:0] mem_word(input logic [10:0] a);
        return 32'hC0DE_0000 ^ {a, 10'h0, a};
    endfunction

    always @(posedge clk) begin
        if (imem_read) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what decode sees, plus the next address to fetch.
    bit          m_boot = 1'b1;
    bit          m_flush = 1'b0;
    bit          m_have = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ins = NOP;
    logic [31:0] m_next = 32'h0;

    always @(posedge clk) begin
        logic [31:0] t;
        if (rst) begin
            m_boot = 1'b1; m_flush = 1'b0; m_have = 1'b0; m_mis = 1'b0;
            m_next = 32'h0;
        end else if (branch_taken || trap_taken) begin
            t = jump_target;
            m_boot = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (t[1:0] != 2'b00) begin
                m_have = 1'b1; m_mis = 1'b1; m_flush = 1'b0;
                m_pc = t; m_ins = NOP; m_next = t;
            end else begin
                m_have = 1'b0; m_mis = 1'b0; m_flush = 1'b1; m_next = t;
            end
`else
            t = {t[31:2], 2'b00};
            m_have = 1'b0; m_mis = 1'b0; m_flush = 1'b1; m_next = t;
`endif
        end else if (m_boot || m_flush || (m_have && !m_mis && !stall)) begin
            m_have = 1'b1; m_pc = m_next; m_ins = mem_word(m_next[12:2]);
            m_next = m_next + 32'd4;
            m_boot = 1'b0; m_flush = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic exp_rd;
        if (rst) begin
            chk("m_rst_valid", {31'h0, if_valid}, 32'h0);
            chk("m_rst_read", {31'h0, imem_read}, 32'h0);
            chk("m_rst_flush", {31'h0, pipe_flush}, 32'h0);
            chk("m_rst_mis", {31'h0, if_misalign}, 32'h0);
            chk("m_rst_ins", if_ins, NOP);
            chk("m_rst_pc", if_pc, 32'h0);
        end else begin
            exp_rd = !(branch_taken || trap_taken) &&
                     (m_boot || m_flush || (m_have && !m_mis && !stall));
            chk("m_read", {31'h0, imem_read}, {31'h0, exp_rd});
            if (exp_rd) chk("m_addr", {21'h0, imem_addr}, {21'h0, m_next[12:2]});
            chk("m_valid", {31'h0, if_valid}, {31'h0, m_have});
            chk("m_flush", {31'h0, pipe_flush}, {31'h0, m_flush});
            chk("m_mis", {31'h0, if_misalign}, {31'h0, m_mis});
            if (m_have) begin
                chk("m_pc", if_pc, m_pc);
                chk("m_ins", if_ins, m_ins);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic br, input logic tr, input logic [31:0] tgt);
        branch_taken = br;
        trap_taken   = tr;
        jump_target  = tgt;
    endtask

    logic [31:0] held_ins;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ins", if_ins, NOP);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("boot_read", {31'h0, imem_read}, 32'h1);
        chk("boot_addr", {21'h0, imem_addr}, 32'h0);
        chk("boot_valid", {31'h0, if_valid}, 32'h0);
        step(); @(negedge clk);
        chk("seq_pc0", if_pc, 32'h0);
        chk("seq_valid0", {31'h0, if_valid}, 32'h1);
        step(); @(negedge clk);
        chk("seq_pc4", if_pc, 32'h4);
        // Stall for three cycles while pc=8 is presented.
        step(); stall = 1'b1; @(negedge clk);
        chk("seq_pc8", if_pc, 32'h8);
        chk("pc8_ins", if_ins, 32'hC09E_0002);
        chk("stall_read", {31'h0, imem_read}, 32'h0);
        held_ins = if_ins;
        for (int i = 0; i < 2; i++) begin
            step(); @(negedge clk);
            chk("hold_pc", if_pc, 32'h8);
            chk("hold_ins", if_ins, held_ins);
            chk("hold_read", {31'h0, imem_read}, 32'h0);
        end
        step(); stall = 1'b0; @(negedge clk);
        chk("release_pc", if_pc, 32'h8);
        chk("release_addr", {21'h0, imem_addr}, 32'h3);
        step(); @(negedge clk);
        chk("after_stall_pc", if_pc, 32'hC);
        // Branch together with stall.
        redirect(1'b1, 1'b0, 32'h100); stall = 1'b1;
        @(negedge clk);
        chk("br_read", {31'h0, imem_read}, 32'h0);
        step(); redirect(1'b0, 1'b0, 32'h0); stall = 1'b0;
        @(negedge clk);
        chk("br_flush", {31'h0, pipe_flush}, 32'h1);
        chk("br_flush_valid", {31'h0, if_valid}, 32'h0);
        step(); @(negedge clk);
        chk("br_pc", if_pc, 32'h100);
        chk("br_noflush", {31'h0, pipe_flush}, 32'h0);
        // Wrap at the top of the address space.
        redirect(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(); redirect(1'b0, 1'b0, 32'h0);
        step(); @(negedge clk);
        chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
        step(); @(negedge clk);
        chk("wrap_pc_zero", if_pc, 32'h0);
        // Simultaneous branch and trap form one redirect.
        redirect(1'b1, 1'b1, 32'h40);
        step(); redirect(1'b0, 1'b0, 32'h0);
        step(); @(negedge clk);
        chk("both_pc", if_pc, 32'h40);
        // Redirect while already flushing restarts the flush.
        redirect(1'b1, 1'b0, 32'h80);
        step(); redirect(1'b0, 1'b1, 32'h300);
        step(); redirect(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("reflush", {31'h0, pipe_flush}, 32'h1);
        chk("reflush_addr", {21'h0, imem_addr}, 32'hC0);
        step(); @(negedge clk);
        chk("reflush_pc", if_pc, 32'h300);
        step(); stall = 1'b1;
        step(); redirect(1'b1, 1'b0, 32'h102);
        step(); redirect(1'b0, 1'b0, 32'h0); stall = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_flag", {31'h0, if_misalign}, 32'h1);
            chk("mis_ins", if_ins, NOP);
            chk("mis_pc", if_pc, 32'h102);
            chk("mis_read", {31'h0, imem_read}, 32'h0);
            step();
        end
        redirect(1'b0, 1'b1, 32'h200);
        step(); redirect(1'b0, 1'b0, 32'h0);
        step(); @(negedge clk);
        chk("mis_exit_pc", if_pc, 32'h200);
        chk("mis_exit_flag", {31'h0, if_misalign}, 32'h0);
`else
        @(negedge clk);
        chk("align_flush", {31'h0, pipe_flush}, 32'h1);
        step(); @(negedge clk);
        chk("align_pc", if_pc, 32'h100);
        chk("align_mis", {31'h0, if_misalign}, 32'h0);
`endif
        // Reset in the middle of a hold.
        step(); stall = 1'b1;
        step(); rst = 1'b1;
        @(negedge clk);
        chk("hold_rst_valid", {31'h0, if_valid}, 32'h0);
        chk("hold_rst_ins", if_ins, NOP);
        chk("hold_rst_read", {31'h0, imem_read}, 32'h0);
        step(); stall = 1'b0;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("replay_boot_valid", {31'h0, if_valid}, 32'h0);
        step(); @(negedge clk);
        chk("replay_pc0", if_pc, 32'h0);
        step(); @(negedge clk);
        chk("replay_pc4", if_pc, 32'h4);
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
